reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Parametrised reorder buffer for the Tomasulo RV32I core. It replaces the hand-coded 128-entry array of parallel RoB regs with a self-contained circular queue. Issue allocates entries in program order, one or more CDB ports mark them complete, and the head entry is retired in order to the register file and RAT. It adds what the inline version lacks: full/empty backpressure, multi-port CDB capture, pointer wrap-around, a pipeline flush, and operand lookup ports for issue.

## Interface
Parameters:
- DEPTH, 16, number of entries; must be a power of two, at least 2
- DATA_W, 32, result value width
- ADDR_W, 5, architectural destination register width
- OP_W, 6, instruction-type code width
- IDX_W, 11, instruction index width
- NCDB, 2, number of CDB write ports
- TAG_W, $clog2(DEPTH), entry tag width (derived; do not override)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- alloc_valid  in  1  issue requests an entry
- alloc_ready  out  1  entry available (not full)
- alloc_op  in  OP_W  instruction type
- alloc_has_dest  in  1  instruction writes a register
- alloc_dest  in  ADDR_W  destination register
- alloc_index  in  IDX_W  instruction number
- alloc_tag  out  TAG_W  tag granted (current tail)
- cdb_valid  in  NCDB  per-port broadcast strobe
- cdb_tag  in  NCDB*TAG_W  packed tags, port 0 in the LSBs
- cdb_value  in  NCDB*DATA_W  packed results
- commit_valid  out  1  head entry is busy and done
- commit_ready  in  1  register file accepts the retire
- commit_op, commit_has_dest, commit_dest, commit_value, commit_index, commit_tag  out  head entry fields
- lk_tag  in  2*TAG_W  two operand lookup tags
- lk_ready  out  2  looked-up entry has a result
- lk_value  out  2*DATA_W  looked-up result
- count  out  TAG_W+1  occupied entries

## Operation
- Per-entry state: busy, done, op, has_dest, dest, value, index.
- State: head and tail pointers of TAG_W bits, plus count.
- Allocate on alloc_valid && alloc_ready:
  - entry[tail] gets busy=1, done=0, value=0 and the alloc fields.
  - tail increments and wraps modulo DEPTH.
  - alloc_tag always equals tail.
- alloc_ready = (count != DEPTH). It does not account for a commit in the same cycle, so a full buffer refuses allocation even while retiring.
- CDB capture on cdb_valid[p] when entry[cdb_tag[p]] is busy and not done: set done=1 and value=cdb_value[p].
  - Broadcasts to non-busy or already-done entries are ignored.
  - If two ports target the same tag in one cycle, the lowest port number wins.
- Commit:
  - commit_valid = busy[head] && done[head], combinational from registered state.
  - On commit_valid && commit_ready: clear busy[head] and increment head with wrap.
  - commit_* outputs always show the head entry fields.
- count: +1 on allocate, -1 on commit, unchanged when both happen in the same cycle.
- Flush takes priority over allocate, CDB and commit. It clears all busy/done bits and sets head=tail=count=0.
- Lookup: lk_ready[i] = busy && done for entry[lk_tag[i]]; lk_value[i] is that entry's value.

## Timing
- Reset (asynchronous, active-low):
  - head=tail=count=0; all busy/done=0; all values 0.
  - Outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, commit_* = 0, lk_ready=0, lk_value=0.
- Reset asserted mid-operation discards every entry immediately, without waiting for a clock edge.
- An allocated entry is visible to CDB capture and lookup from the next cycle.
- A CDB write becomes a commit candidate one cycle later: a broadcast to the head at edge N gives commit_valid in cycle N+1.
- Allocating and committing the same entry in one cycle cannot happen, since a just-allocated entry is never done.
- Empty (count=0): commit_valid=0. Full (count=DEPTH): alloc_ready=0.

## Configuration
- ROB_CDB_BYPASS_EN defined:
  - Lookup also checks the live CDB ports, lowest port first.
  - A matching cdb_valid on a busy entry forces lk_ready=1 and lk_value=cdb_value in the same cycle.
- Undefined: lookup reflects registered state only, so a result appears one cycle after its broadcast.

## Structure
- Shared package rob_pkg holds:
  - the OP_W opcode encodings shared with the issue stage and reservation stations;
  - the ROB entry struct typedef;
  - the default DEPTH, DATA_W, ADDR_W and IDX_W constants.
- One sub-module, rob_cdb_match: given the CDB port arrays and one tag, it returns hit and value with lowest-port priority. It is reused by capture (per entry) and by bypass lookup.

## Test plan
- Reset, then allocate 3 entries (dest 1,2,3): alloc_tag 0,1,2; count=3; commit_valid=0.
- CDB tag 1 value 0x55 first, then tag 0 value 0xAA: commit_valid rises only after tag 0 completes. Retires follow in order: 0xAA to dest 1, then 0x55 to dest 2.
- Fill DEPTH=16: alloc_ready=0 at count=16. Commit one while holding alloc_valid: no allocation that cycle, allocation the next cycle with alloc_tag=0 (wrap-around).
- Both CDB ports target tag 4 with 0x11 and 0x22 in one cycle: entry 4 stores 0x11.
- With ROB_CDB_BYPASS_EN, lk_tag=5 during a CDB broadcast of tag 5, value 0x7: lk_ready=1 and lk_value=0x7 the same cycle. Without the macro, both appear one cycle later.
- flush with 6 entries live plus simultaneous alloc and CDB: next cycle count=0, head=tail=0, commit_valid=0. Assert reset mid-stream: outputs clear immediately.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: opcode encodings used by issue and
// the reservation stations, the entry record, and default geometry.
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_ADDR_W = 5;
  localparam int ROB_IDX_W  = 11;
  localparam int ROB_OP_W   = 6;

  typedef enum logic [ROB_OP_W-1:0] {
    OP_ALU    = 6'd0,
    OP_LOAD   = 6'd1,
    OP_STORE  = 6'd2,
    OP_BRANCH = 6'd3,
    OP_JAL    = 6'd4,
    OP_JALR   = 6'd5,
    OP_LUI    = 6'd6,
    OP_AUIPC  = 6'd7
  } rob_op_e;

  typedef struct packed {
    logic busy;
    logic done;
  } rob_status_t;

  typedef struct packed {
    rob_status_t             status;
    logic [ROB_OP_W-1:0]     op;
    logic                    hasDest;
    logic [ROB_ADDR_W-1:0]   dest;
    logic [ROB_DATA_W-1:0]   value;
    logic [ROB_IDX_W-1:0]    index;
  } rob_entry_t;

endpackage

// File: rtl/rob_cdb_match.sv
// Searches the CDB ports for one tag; the lowest-numbered matching port wins.
module rob_cdb_match
  import rob_pkg::*;
#(
  parameter int NCDB   = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic [NCDB-1:0]        cdb_valid_i,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag_i,
  input  logic [NCDB*DATA_W-1:0] cdb_value_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   hit_o,
  output logic [DATA_W-1:0]      value_o
);

  // Scan from the highest port down so the lowest port's match is the last one written.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    for (int p = NCDB - 1; p >= 0; p--) begin
      if (cdb_valid_i[p] && (cdb_tag_i[p*TAG_W +: TAG_W] == tag_i)) begin
        hit_o   = 1'b1;
        value_o = cdb_value_i[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/retire, multi-port CDB completion, operand lookup.
// Define ROB_CDB_BYPASS_EN to let lookups see results broadcast on the CDB in the same cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = ROB_DATA_W,
  parameter int ADDR_W = ROB_ADDR_W,
  parameter int OP_W   = ROB_OP_W,
  parameter int IDX_W  = ROB_IDX_W,
  parameter int NCDB   = 2,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [OP_W-1:0]        alloc_op,
  input  logic                   alloc_has_dest,
  input  logic [ADDR_W-1:0]      alloc_dest,
  input  logic [IDX_W-1:0]       alloc_index,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic [NCDB-1:0]        cdb_valid,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_value,
  output logic                   commit_valid,
  input  logic                   commit_ready,
  output logic [OP_W-1:0]        commit_op,
  output logic                   commit_has_dest,
  output logic [ADDR_W-1:0]      commit_dest,
  output logic [DATA_W-1:0]      commit_value,
  output logic [IDX_W-1:0]       commit_index,
  output logic [TAG_W-1:0]       commit_tag,
  input  logic [2*TAG_W-1:0]     lk_tag,
  output logic [1:0]             lk_ready,
  output logic [2*DATA_W-1:0]    lk_value,
  output logic [TAG_W:0]         count
);

  rob_status_t         status_q  [DEPTH];
  logic [OP_W-1:0]     op_q      [DEPTH];
  logic                hasDest_q [DEPTH];
  logic [ADDR_W-1:0]   dest_q    [DEPTH];
  logic [DATA_W-1:0]   value_q   [DEPTH];
  logic [IDX_W-1:0]    index_q   [DEPTH];

  logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]      count_q, count_d;
  logic                doAlloc, doCommit;

  logic [DEPTH-1:0]    capHit;
  logic [DATA_W-1:0]   capValue [DEPTH];

  assign alloc_ready     = (count_q != (TAG_W+1)'(DEPTH));
  assign alloc_tag       = tail_q;
  assign count           = count_q;
  assign commit_valid    = status_q[head_q].busy && status_q[head_q].done;
  assign commit_op       = op_q[head_q];
  assign commit_has_dest = hasDest_q[head_q];
  assign commit_dest     = dest_q[head_q];
  assign commit_value    = value_q[head_q];
  assign commit_index    = index_q[head_q];
  assign commit_tag      = head_q;

  for (genvar e = 0; e < DEPTH; e++) begin : g_cap
    rob_cdb_match #(.NCDB(NCDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match (
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_value_i (cdb_value),
      .tag_i       (TAG_W'(e)),
      .hit_o       (capHit[e]),
      .value_o     (capValue[e])
    );
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    doAlloc  = alloc_valid && alloc_ready;
    doCommit = commit_valid && commit_ready;
    head_d   = doCommit ? head_q + TAG_W'(1) : head_q;
    tail_d   = doAlloc ? tail_q + TAG_W'(1) : tail_q;
    count_d  = count_q;
    if (doAlloc && !doCommit) count_d = count_q + 1'b1;
    if (!doAlloc && doCommit) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        status_q[e]  <= '0;
        op_q[e]      <= '0;
        hasDest_q[e] <= 1'b0;
        dest_q[e]    <= '0;
        value_q[e]   <= '0;
        index_q[e]   <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) status_q[e] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // A freshly allocated slot was idle, so capture and commit cannot touch it this cycle.
      for (int e = 0; e < DEPTH; e++) begin
        if (doAlloc && (tail_q == TAG_W'(e))) begin
          status_q[e]  <= '{busy: 1'b1, done: 1'b0};
          op_q[e]      <= alloc_op;
          hasDest_q[e] <= alloc_has_dest;
          dest_q[e]    <= alloc_dest;
          value_q[e]   <= '0;
          index_q[e]   <= alloc_index;
        end else begin
          if (capHit[e] && status_q[e].busy && !status_q[e].done) begin
            status_q[e].done <= 1'b1;
            value_q[e]       <= capValue[e];
          end
          if (doCommit && (head_q == TAG_W'(e))) status_q[e].busy <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_lk
    logic [TAG_W-1:0]  lkTag;
    logic              lkReady;
    logic [DATA_W-1:0] lkValue;

    assign lkTag = lk_tag[i*TAG_W +: TAG_W];

`ifdef ROB_CDB_BYPASS_EN
    logic              byHit;
    logic [DATA_W-1:0] byValue;

    rob_cdb_match #(.NCDB(NCDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_bypass (
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_value_i (cdb_value),
      .tag_i       (lkTag),
      .hit_o       (byHit),
      .value_o     (byValue)
    );

    always_comb begin
      lkReady = status_q[lkTag].busy && status_q[lkTag].done;
      lkValue = value_q[lkTag];
      if (byHit && status_q[lkTag].busy) begin
        lkReady = 1'b1;
        lkValue = byValue;
      end
    end
`else
    always_comb begin
      lkReady = status_q[lkTag].busy && status_q[lkTag].done;
      lkValue = value_q[lkTag];
    end
`endif

    assign lk_ready[i]                 = lkReady;
    assign lk_value[i*DATA_W +: DATA_W] = lkValue;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer (DEPTH=16, NCDB=2); honours ROB_CDB_BYPASS_EN.
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [5:0]        alloc_op;
  logic              alloc_has_dest;
  logic [4:0]        alloc_dest;
  logic [10:0]       alloc_index;
  logic [TAG_W-1:0]  alloc_tag;
  logic [1:0]        cdb_valid;
  logic [2*TAG_W-1:0] cdb_tag;
  logic [2*DATA_W-1:0] cdb_value;
  logic              commit_valid;
  logic              commit_ready;
  logic [5:0]        commit_op;
  logic              commit_has_dest;
  logic [4:0]        commit_dest;
  logic [DATA_W-1:0] commit_value;
  logic [10:0]       commit_index;
  logic [TAG_W-1:0]  commit_tag;
  logic [2*TAG_W-1:0] lk_tag;
  logic [1:0]        lk_ready;
  logic [2*DATA_W-1:0] lk_value;
  logic [TAG_W:0]    count;

  reorder_buffer dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_has_dest(alloc_has_dest), .alloc_dest(alloc_dest), .alloc_index(alloc_index),
    .alloc_tag(alloc_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_op(commit_op),
    .commit_has_dest(commit_has_dest), .commit_dest(commit_dest), .commit_value(commit_value),
    .commit_index(commit_index), .commit_tag(commit_tag), .lk_tag(lk_tag),
    .lk_ready(lk_ready), .lk_value(lk_value), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [10:0] index;
    logic [5:0]  op;
  } sb_t;

  sb_t         sbQ[$];
  logic        modelBusy  [DEPTH];
  logic        modelDone  [DEPTH];
  logic [31:0] modelValue [DEPTH];
  int          modelHead, modelTail, modelCount;
  int          testCount = 0;
  int          failCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
      end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic modelClear();
    for (int e = 0; e < DEPTH; e++) begin
      modelBusy[e] = 1'b0;
      modelDone[e] = 1'b0;
    end
    modelHead = 0; modelTail = 0; modelCount = 0;
    sbQ.delete();
  endtask

  task automatic allocOne(input logic [4:0] dest, input logic [10:0] index, input logic [5:0] op);
    sb_t item;
    alloc_valid = 1'b1; alloc_dest = dest; alloc_index = index; alloc_op = op; alloc_has_dest = 1'b1;
    #1;
    checkOutput("alloc_ready", {63'd0, alloc_ready}, 64'd1);
    checkOutput("alloc_tag", {60'd0, alloc_tag}, 64'(modelTail));
    applyStimulus();
    alloc_valid = 1'b0;
    item.tag = modelTail; item.dest = dest; item.index = index; item.op = op;
    sbQ.push_back(item);
    modelBusy[modelTail] = 1'b1; modelDone[modelTail] = 1'b0; modelValue[modelTail] = '0;
    modelTail = (modelTail + 1) % DEPTH;
    modelCount++;
  endtask

  task automatic cdbOne(input int port, input int tag, input logic [31:0] value);
    cdb_valid = '0; cdb_valid[port] = 1'b1;
    cdb_tag[port*TAG_W +: TAG_W] = TAG_W'(tag);
    cdb_value[port*DATA_W +: DATA_W] = value;
    applyStimulus();
    cdb_valid = '0;
    if (modelBusy[tag] && !modelDone[tag]) begin
      modelDone[tag] = 1'b1;
      modelValue[tag] = value;
    end
  endtask

  task automatic commitOne();
    sb_t exp;
    commit_ready = 1'b1;
    #1;
    checkOutput("commit_valid", {63'd0, commit_valid}, 64'd1);
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      exp = sbQ.pop_front();
      checkOutput("commit_tag", {60'd0, commit_tag}, 64'(exp.tag));
      checkOutput("commit_dest", {59'd0, commit_dest}, {59'd0, exp.dest});
      checkOutput("commit_index", {53'd0, commit_index}, {53'd0, exp.index});
      checkOutput("commit_op", {58'd0, commit_op}, {58'd0, exp.op});
      checkOutput("commit_value", {32'd0, commit_value}, {32'd0, modelValue[exp.tag]});
    end
    applyStimulus();
    commit_ready = 1'b0;
    modelBusy[modelHead] = 1'b0;
    modelHead = (modelHead + 1) % DEPTH;
    modelCount--;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_op = '0; alloc_has_dest = 1'b0;
    alloc_dest = '0; alloc_index = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    commit_ready = 1'b0; lk_tag = '0;
    modelClear();
    for (int e = 0; e < DEPTH; e++) modelValue[e] = '0;
    #12;
    checkOutput("reset_alloc_ready", {63'd0, alloc_ready}, 64'd1);
    checkOutput("reset_alloc_tag", {60'd0, alloc_tag}, 64'd0);
    checkOutput("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
    checkOutput("reset_commit_value", {32'd0, commit_value}, 64'd0);
    checkOutput("reset_commit_dest", {59'd0, commit_dest}, 64'd0);
    checkOutput("reset_count", {59'd0, count}, 64'd0);
    checkOutput("reset_lk_ready", {62'd0, lk_ready}, 64'd0);
    checkOutput("reset_lk_value", lk_value, 64'd0);
    reset = 1'b1;
    applyStimulus();

    // Three allocations, completed out of order, retired in order.
    allocOne(5'd1, 11'd100, 6'd0);
    allocOne(5'd2, 11'd101, 6'd1);
    allocOne(5'd3, 11'd102, 6'd3);
    checkOutput("count_after_3", {59'd0, count}, 64'(modelCount));
    checkOutput("commit_valid_none_done", {63'd0, commit_valid}, 64'd0);
    cdbOne(0, 1, 32'h55);
    checkOutput("commit_valid_tag1_only", {63'd0, commit_valid}, 64'd0);
    cdbOne(1, 0, 32'hAA);
    checkOutput("commit_valid_tag0_done", {63'd0, commit_valid}, 64'd1);
    commitOne();
    commitOne();
    checkOutput("commit_valid_tag2_pending", {63'd0, commit_valid}, 64'd0);
    cdbOne(0, 2, 32'h33);
    commitOne();
    checkOutput("count_empty", {59'd0, count}, 64'd0);

    // Flush on an empty buffer resets the pointers to zero.
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    modelClear();
    checkOutput("alloc_tag_after_flush", {60'd0, alloc_tag}, 64'd0);

    // Fill to DEPTH, then commit while allocation is held.
    for (int i = 0; i < DEPTH; i++) allocOne(5'(i + 4), 11'(200 + i), 6'd0);
    checkOutput("full_alloc_ready", {63'd0, alloc_ready}, 64'd0);
    checkOutput("full_count", {59'd0, count}, 64'd16);
    cdbOne(0, 0, 32'h99);
    alloc_valid = 1'b1; alloc_dest = 5'd20; alloc_index = 11'd300; alloc_op = 6'd2;
    #1;
    checkOutput("full_refuses_while_commit", {63'd0, alloc_ready}, 64'd0);
    commitOne();
    checkOutput("count_after_commit_full", {59'd0, count}, 64'd15);
    allocOne(5'd20, 11'd300, 6'd2);
    checkOutput("count_refill", {59'd0, count}, 64'd16);

    // Both ports hit tag 4: port 0 wins.
    cdb_valid = 2'b11;
    cdb_tag = {4'd4, 4'd4};
    cdb_value = {32'h22, 32'h11};
    applyStimulus();
    cdb_valid = '0;
    modelDone[4] = 1'b1; modelValue[4] = 32'h11;
    lk_tag = {4'd6, 4'd4};
    #1;
    checkOutput("lk_ready_tag4_tag6", {62'd0, lk_ready}, 64'b01);
    checkOutput("lk_value_tag4", {32'd0, lk_value[31:0]}, {32'd0, modelValue[4]});

    // Lookup of tag 5 during its broadcast on port 1.
    lk_tag = {4'd6, 4'd5};
    cdb_valid = 2'b10;
    cdb_tag = {4'd5, 4'd0};
    cdb_value = {32'h7, 32'h0};
    #1;
`ifdef ROB_CDB_BYPASS_EN
    checkOutput("lk_ready_bypass", {63'd0, lk_ready[0]}, 64'd1);
    checkOutput("lk_value_bypass", {32'd0, lk_value[31:0]}, 64'h7);
`else
    checkOutput("lk_ready_no_bypass", {63'd0, lk_ready[0]}, 64'd0);
    checkOutput("lk_value_no_bypass", {32'd0, lk_value[31:0]}, 64'h0);
`endif
    applyStimulus();
    cdb_valid = '0;
    modelDone[5] = 1'b1; modelValue[5] = 32'h7;
    #1;
    checkOutput("lk_ready_tag5_next", {62'd0, lk_ready}, 64'b01);
    checkOutput("lk_value_tag5_next", {32'd0, lk_value[31:0]}, 64'h7);

    // Complete and retire tags 1..10, leaving 6 live entries.
    for (int t = 1; t <= 10; t++)
      if (t != 4 && t != 5) cdbOne(t % 2, t, 32'($urandom));
    for (int i = 0; i < 10; i++) commitOne();
    checkOutput("count_six_live", {59'd0, count}, 64'd6);

    // Flush beats a simultaneous allocate and broadcast.
    flush = 1'b1; alloc_valid = 1'b1;
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd11}; cdb_value = {32'h0, 32'hDEAD};
    lk_tag = {4'd12, 4'd11};
    applyStimulus();
    flush = 1'b0; alloc_valid = 1'b0; cdb_valid = '0;
    modelClear();
    #1;
    checkOutput("flush_count", {59'd0, count}, 64'd0);
    checkOutput("flush_alloc_tag", {60'd0, alloc_tag}, 64'd0);
    checkOutput("flush_commit_tag", {60'd0, commit_tag}, 64'd0);
    checkOutput("flush_commit_valid", {63'd0, commit_valid}, 64'd0);
    checkOutput("flush_lk_ready", {62'd0, lk_ready}, 64'd0);

    // Asynchronous reset in mid-cycle.
    allocOne(5'd9, 11'd400, 6'd4);
    allocOne(5'd10, 11'd401, 6'd5);
    cdbOne(0, 0, 32'hAB);
    lk_tag = {4'd1, 4'd0};
    #1;
    checkOutput("pre_reset_commit_valid", {63'd0, commit_valid}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_count", {59'd0, count}, 64'd0);
    checkOutput("async_reset_commit_valid", {63'd0, commit_valid}, 64'd0);
    checkOutput("async_reset_commit_value", {32'd0, commit_value}, 64'd0);
    checkOutput("async_reset_alloc_tag", {60'd0, alloc_tag}, 64'd0);
    checkOutput("async_reset_lk_ready", {62'd0, lk_ready}, 64'd0);
    modelClear();
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    allocOne(5'd11, 11'd500, 6'd6);
    checkOutput("post_reset_count", {59'd0, count}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
